// File: rtl/fpu_ret_collect.sv
// fpu_ret_collect
// Collects completions from FPU ports u1/u3/u5 and forwards them on one
// retire channel. Each completion is paired with the ROB tag captured when
// the op was issued, buffered in a small per-port FIFO, and the three FIFOs
// are merged round-robin into a single registered valid/ready output slot.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   uN_issue, uN_tag               op issued on port N this cycle, its ROB tag
//   uN_ret, uN_ret_en              completion word from port N and its strobe
//   ret_valid, ret_ready           retire channel handshake
//   ret_port, ret_tag, ret_data    source port (0=u1,1=u3,2=u5), tag, word
//   ovf                            sticky per port: completion dropped, FIFO full
//   orphan                         sticky per port: ret_en with no issued op
//   err_clr                        clears ovf/orphan (a new event wins)
module fpu_ret_collect #(
  parameter int LAT   = 5,
  parameter int DEPTH = 4,
  parameter int TAGW  = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            u1_issue,
  input  logic [TAGW-1:0] u1_tag,
  input  logic [13:0]     u1_ret,
  input  logic            u1_ret_en,
  input  logic            u3_issue,
  input  logic [TAGW-1:0] u3_tag,
  input  logic [13:0]     u3_ret,
  input  logic            u3_ret_en,
  input  logic            u5_issue,
  input  logic [TAGW-1:0] u5_tag,
  input  logic [13:0]     u5_ret,
  input  logic            u5_ret_en,
  output logic            ret_valid,
  input  logic            ret_ready,
  output logic [1:0]      ret_port,
  output logic [TAGW-1:0] ret_tag,
  output logic [13:0]     ret_data,
  output logic [2:0]      ovf,
  output logic [2:0]      orphan,
  input  logic            err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Per-port views of the inputs, index 0=u1, 1=u3, 2=u5
  logic [2:0]      issue_s;
  logic [2:0]      ret_en_s;
  logic [TAGW-1:0] tag_in_s [3];
  logic [13:0]     ret_in_s [3];

  assign issue_s     = {u5_issue, u3_issue, u1_issue};
  assign ret_en_s    = {u5_ret_en, u3_ret_en, u1_ret_en};
  assign tag_in_s[0] = u1_tag;
  assign tag_in_s[1] = u3_tag;
  assign tag_in_s[2] = u5_tag;
  assign ret_in_s[0] = u1_ret;
  assign ret_in_s[1] = u3_ret;
  assign ret_in_s[2] = u5_ret;

  // Tag pipes: stage LAT-1 holds the op whose completion is due this cycle
  logic [LAT-1:0]  pipe_vld_r [3];
  logic [TAGW-1:0] pipe_tag_r [3][LAT];

  // Per-port FIFOs
  logic [TAGW-1:0] fifo_tag_r  [3][DEPTH];
  logic [13:0]     fifo_data_r [3][DEPTH];
  logic [PW-1:0]   wr_ptr_r [3];
  logic [PW-1:0]   rd_ptr_r [3];
  logic [CW-1:0]   cnt_r    [3];
  logic [1:0]      rr_r;

  logic            load_s;
  logic            pick_found_s;
  logic [1:0]      pick_port_s;
  logic [1:0]      cand_s;
  logic [TAGW-1:0] pick_tag_s;
  logic [13:0]     pick_data_s;
  logic [2:0]      pop_s;
  logic [2:0]      push_s;
  logic [2:0]      ovf_set_s;
  logic [2:0]      orphan_set_s;

  // (p + k) mod 3 for the round-robin search
  function automatic logic [1:0] port_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

  // Round-robin pick among non-empty FIFOs; only stored entries are visible
  always_comb begin
    load_s       = !ret_valid || ret_ready;
    pick_found_s = 1'b0;
    pick_port_s  = 2'd0;
    cand_s       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand_s = port_add(rr_r, 2'(k));
      if (!pick_found_s && (cnt_r[cand_s] != {CW{1'b0}})) begin
        pick_found_s = 1'b1;
        pick_port_s  = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Head-of-FIFO read for the winner, pop/push/flag decisions per port
  always_comb begin
    pick_tag_s   = {TAGW{1'b0}};
    pick_data_s  = 14'd0;
    pop_s        = 3'b000;
    push_s       = 3'b000;
    ovf_set_s    = 3'b000;
    orphan_set_s = 3'b000;
    for (int p = 0; p < 3; p++) begin
      if (pick_port_s == 2'(p)) begin
        pick_tag_s  = fifo_tag_r[p][rd_ptr_r[p]];
        pick_data_s = fifo_data_r[p][rd_ptr_r[p]];
      end else begin
        pick_tag_s  = pick_tag_s;
        pick_data_s = pick_data_s;
      end
      pop_s[p] = load_s && pick_found_s && (pick_port_s == 2'(p));
      // A full FIFO still accepts when its head leaves in the same cycle
      if (ret_en_s[p] && pipe_vld_r[p][LAT-1]) begin
        push_s[p]    = (cnt_r[p] < CW'(DEPTH)) || pop_s[p];
        ovf_set_s[p] = !push_s[p];
      end else begin
        push_s[p]    = 1'b0;
        ovf_set_s[p] = 1'b0;
      end
      orphan_set_s[p] = ret_en_s[p] && !pipe_vld_r[p][LAT-1];
    end
  end

  // Tag pipe valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        pipe_vld_r[p] <= {LAT{1'b0}};
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        pipe_vld_r[p] <= {pipe_vld_r[p][LAT-2:0], issue_s[p]};
      end
    end
  end

  // Tag pipe and FIFO payload storage; qualified by valid bits and counts
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      pipe_tag_r[p][0] <= tag_in_s[p];
      for (int s = 1; s < LAT; s++) begin
        pipe_tag_r[p][s] <= pipe_tag_r[p][s-1];
      end
      if (push_s[p]) begin
        fifo_tag_r[p][wr_ptr_r[p]]  <= pipe_tag_r[p][LAT-1];
        fifo_data_r[p][wr_ptr_r[p]] <= ret_in_s[p];
      end
    end
  end

  // FIFO pointers, counts, round-robin pointer, output slot and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        wr_ptr_r[p] <= {PW{1'b0}};
        rd_ptr_r[p] <= {PW{1'b0}};
        cnt_r[p]    <= {CW{1'b0}};
      end
      rr_r      <= 2'd0;
      ret_valid <= 1'b0;
      ret_port  <= 2'd0;
      ret_tag   <= {TAGW{1'b0}};
      ret_data  <= 14'd0;
      ovf       <= 3'b000;
      orphan    <= 3'b000;
    end else begin
      for (int p = 0; p < 3; p++) begin
        wr_ptr_r[p] <= wr_ptr_r[p] + PW'(push_s[p]);
        rd_ptr_r[p] <= rd_ptr_r[p] + PW'(pop_s[p]);
        cnt_r[p]    <= cnt_r[p] + CW'(push_s[p]) - CW'(pop_s[p]);
      end
      if (load_s) begin
        if (pick_found_s) begin
          ret_valid <= 1'b1;
          ret_port  <= pick_port_s;
          ret_tag   <= pick_tag_s;
          ret_data  <= pick_data_s;
          rr_r      <= port_add(pick_port_s, 2'd1);
        end else begin
          ret_valid <= 1'b0;
        end
      end
      ovf    <= ovf_set_s | (ovf & ~{3{err_clr}});
      orphan <= orphan_set_s | (orphan & ~{3{err_clr}});
    end
  end

endmodule

// File: tb/tb_fpu_ret_collect.sv
module tb_fpu_ret_collect;

  localparam int LAT   = 5;
  localparam int DEPTH = 4;
  localparam int TAGW  = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      iss = 3'b000;
  logic [2:0]      ren = 3'b000;
  logic [TAGW-1:0] itag [3];
  logic [13:0]     rdat [3];
  logic            ret_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic            ret_valid;
  logic [1:0]      ret_port;
  logic [TAGW-1:0] ret_tag;
  logic [13:0]     ret_data;
  logic [2:0]      ovf;
  logic [2:0]      orphan;

  int n_cmp = 0;
  int n_bad = 0;
  logic [TAGW-1:0] got [$];
  int n_seen;

  always #5 clk = ~clk;

  fpu_ret_collect #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .u1_issue(iss[0]), .u1_tag(itag[0]), .u1_ret(rdat[0]), .u1_ret_en(ren[0]),
    .u3_issue(iss[1]), .u3_tag(itag[1]), .u3_ret(rdat[1]), .u3_ret_en(ren[1]),
    .u5_issue(iss[2]), .u5_tag(itag[2]), .u5_ret(rdat[2]), .u5_ret_en(ren[2]),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_port(ret_port),
    .ret_tag(ret_tag), .ret_data(ret_data), .ovf(ovf), .orphan(orphan),
    .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]      port;
    logic [TAGW-1:0] tag;
    logic [13:0]     data;
  } ent_t;

  ent_t            mq [$];          // all buffered entries, arrival order
  bit              hv [3][8192];    // issue history per port, by cycle
  logic [TAGW-1:0] ht [3][8192];
  int              cyc = 0;
  int              base = 0;        // first cycle whose issues survived reset
  logic            m_valid = 1'b0;
  logic [1:0]      m_port = 2'd0;
  logic [TAGW-1:0] m_tag = '0;
  logic [13:0]     m_data = 14'd0;
  int              m_rr = 0;
  logic [2:0]      m_ovf = 3'b000;
  logic [2:0]      m_orph = 3'b000;

  function automatic int mcount(input int p);
    int n = 0;
    foreach (mq[i]) if (mq[i].port == 2'(p)) n++;
    return n;
  endfunction

  initial begin
    forever begin : model_step
      bit load;
      int win;
      int pp;
      int ic;
      ent_t e;
      logic [2:0] oset;
      logic [2:0] rset;
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_valid = 1'b0; m_port = 2'd0; m_tag = '0; m_data = 14'd0;
        m_rr = 0; m_ovf = 3'b000; m_orph = 3'b000;
        base = cyc;
      end else begin
        load = !m_valid || ret_ready;
        win  = -1;
        e    = '0;
        if (load) begin
          for (int k = 0; k < 3; k++) begin
            pp = (m_rr + k) % 3;
            if (win < 0 && mcount(pp) > 0) win = pp;
          end
        end
        if (win >= 0) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].port == 2'(win)) begin
              e = mq[i];
              mq.delete(i);
              break;
            end
          end
        end
        oset = 3'b000;
        rset = 3'b000;
        for (int p = 0; p < 3; p++) begin
          if (ren[p]) begin
            ic = cyc - LAT;
            if (ic >= base && hv[p][ic]) begin
              if (mcount(p) < DEPTH) mq.push_back({2'(p), ht[p][ic], rdat[p]});
              else oset[p] = 1'b1;
            end else begin
              rset[p] = 1'b1;
            end
          end
        end
        m_ovf  = oset | (m_ovf & ~{3{err_clr}});
        m_orph = rset | (m_orph & ~{3{err_clr}});
        if (load) begin
          if (win >= 0) begin
            m_valid = 1'b1; m_port = 2'(win); m_tag = e.tag; m_data = e.data;
            m_rr = (win + 1) % 3;
          end else begin
            m_valid = 1'b0;
          end
        end
        for (int p = 0; p < 3; p++) begin
          hv[p][cyc] = iss[p];
          ht[p][cyc] = itag[p];
        end
        cyc++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_ret_valid", 32'(ret_valid), 32'(m_valid));
      if (m_valid) begin
        chk("cmp_ret_port", 32'(ret_port), 32'(m_port));
        chk("cmp_ret_tag", 32'(ret_tag), 32'(m_tag));
        chk("cmp_ret_data", 32'(ret_data), 32'(m_data));
      end
      chk("cmp_ovf", 32'(ovf), 32'(m_ovf));
      chk("cmp_orphan", 32'(orphan), 32'(m_orph));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss = 3'b000; ren = 3'b000; err_clr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      itag[p] = '0;
      rdat[p] = 14'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic triple(input logic [TAGW-1:0] t0, input string nm);
    iss = 3'b111; itag[0] = t0; itag[1] = t0 + 9'd1; itag[2] = t0 + 9'd2;
    tick();
    idle();
    repeat (LAT - 1) tick();
    ren = 3'b111; rdat[0] = 14'h0021; rdat[1] = 14'h0022; rdat[2] = 14'h0023;
    tick();
    idle();
    chk({nm, "_gap_valid"}, 32'(ret_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({nm, "_valid"}, 32'(ret_valid), 32'd1);
      chk({nm, "_port"}, 32'(ret_port), 32'(k));
      chk({nm, "_tag"}, 32'(ret_tag), 32'(t0) + 32'(k));
    end
    tick();
    chk({nm, "_end_valid"}, 32'(ret_valid), 32'd0);
  endtask

  initial begin
    idle();
    tick();
    tick();
    chk("rst_valid", 32'(ret_valid), 32'd0);
    chk("rst_port", 32'(ret_port), 32'd0);
    chk("rst_tag", 32'(ret_tag), 32'd0);
    chk("rst_data", 32'(ret_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_orphan", 32'(orphan), 32'd0);
    rst = 1'b0;

    // Single op on u1: issue at cycle 10, ret_en at 15, output during 17 only
    ret_ready = 1'b1;
    repeat (8) tick();
    iss[0] = 1'b1; itag[0] = 9'h05A;
    tick();
    idle();
    repeat (LAT - 1) tick();
    ren[0] = 1'b1; rdat[0] = 14'h0011;
    tick();
    idle();
    chk("single_c16_valid", 32'(ret_valid), 32'd0);
    tick();
    chk("single_c17_valid", 32'(ret_valid), 32'd1);
    chk("single_port", 32'(ret_port), 32'd0);
    chk("single_tag", 32'(ret_tag), 32'h05A);
    chk("single_data", 32'(ret_data), 32'h0011);
    tick();
    chk("single_c18_valid", 32'(ret_valid), 32'd0);
    chk("single_ovf", 32'(ovf), 32'd0);
    chk("single_orphan", 32'(orphan), 32'd0);

    // Contention: three same-cycle completions, twice; rr wraps back to 0
    do_reset();
    triple(9'd1, "cont1");
    triple(9'd4, "cont2");

    // Backpressure/overflow on u3: tags 10..15 back-to-back, 15 is dropped
    do_reset();
    ret_ready = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      iss[1]  = (c < 6);
      itag[1] = 9'(10 + c);
      ren[1]  = (c >= LAT);
      rdat[1] = 14'(16'h0100 + c);
      tick();
    end
    idle();
    chk("ovf_hold_valid", 32'(ret_valid), 32'd1);
    chk("ovf_hold_port", 32'(ret_port), 32'd1);
    chk("ovf_hold_tag", 32'(ret_tag), 32'd10);
    chk("ovf_flag", 32'(ovf), 32'b010);
    tick();
    chk("ovf_hold_tag2", 32'(ret_tag), 32'd10);
    ret_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      if (ret_valid) got.push_back(ret_tag);
      tick();
    end
    chk("ovf_drain_len", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("ovf_drain_tag", 32'(got[i]), 32'(10 + i));
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Orphan on u5, then err_clr together with a new orphan keeps the bit
    ren[2] = 1'b1; rdat[2] = 14'h0333;
    tick();
    idle();
    chk("orphan_set", 32'(orphan), 32'b100);
    repeat (3) begin
      chk("orphan_no_out", 32'(ret_valid), 32'd0);
      tick();
    end
    ren[2] = 1'b1; err_clr = 1'b1;
    tick();
    idle();
    chk("orphan_set_wins", 32'(orphan), 32'b100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("orphan_cleared", 32'(orphan), 32'd0);

    // Full FIFO plus pop in the same cycle: tags 20..25 on u1, none dropped
    do_reset();
    ret_ready = 1'b0;
    got.delete();
    for (int c = 0; c <= 17; c++) begin
      iss[0]    = (c < 6);
      itag[0]   = 9'(20 + c);
      ren[0]    = (c >= LAT) && (c <= 10);
      rdat[0]   = 14'(16'h0200 + c);
      ret_ready = (c >= 10);
      if (ret_ready && ret_valid) got.push_back(ret_tag);
      tick();
    end
    idle();
    chk("fullpop_ovf", 32'(ovf), 32'd0);
    chk("fullpop_len", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk("fullpop_tag", 32'(got[i]), 32'(20 + i));
    end

    // Reset mid-stream: entries buffered, u3 tags 40..42 in flight
    do_reset();
    ret_ready = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      idle();
      if (c <= 1) begin iss[0] = 1'b1; itag[0] = 9'(30 + c); end
      if (c >= 3 && c <= 5) begin iss[1] = 1'b1; itag[1] = 9'(37 + c); end
      if (c >= 5) begin ren[0] = 1'b1; rdat[0] = 14'(16'h0300 + c); end
      tick();
    end
    idle();
    chk("midrst_pre_valid", 32'(ret_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid_drop", 32'(ret_valid), 32'd0);
    chk("midrst_tag_zero", 32'(ret_tag), 32'd0);
    tick();
    rst = 1'b0;
    ret_ready = 1'b1;
    n_seen = 0;
    for (int c = 8; c <= 18; c++) begin
      ren[1] = (c <= 10);
      if (ret_valid) n_seen++;
      tick();
    end
    idle();
    chk("midrst_orphan", 32'(orphan), 32'b010);
    chk("midrst_no_stale", 32'(n_seen), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
